fht_io_seq: RTL and testbench

FHT_IO_SEQ -- requirements
Module: fht_io_seq

---
 rtl/fht_io_pkg.sv | 32 +++
 rtl/fht_io_seq_if.sv | 25 ++
 rtl/fht_skid_buf.sv | 55 +++++
 rtl/fht_io_seq.sv | 146 ++++++++++++++
 tb/tb_fht_io_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fht_io_pkg.sv
// Shared types and helpers for the FHT sample I/O sequencer.
// Holds the sequencer state encoding and the index bit-reversal.
`ifndef A_BIT
`define A_BIT 2
`endif
`ifndef D_BIT
`define D_BIT 16
`endif

package fht_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4
  } state_e;

  function automatic logic [31:0] bit_reverse(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_io_seq_if.sv
// Sample-stream and control handshake bundle of the FHT I/O sequencer.
// slave = sequencer side, master = producer/consumer side.
interface fht_io_seq_if #(
  parameter int D_BIT = 16
);
  logic             iSTART;
  logic             iVALID;
  logic             oREADY;
  logic [D_BIT-1:0] iDATA;
  logic             oVALID;
  logic             iREADY;
  logic [D_BIT-1:0] oDATA;
  logic             oBUSY;
  logic             oFRAME_DONE;

  modport slave (
    input  iSTART, iVALID, iDATA, iREADY,
    output oREADY, oVALID, oDATA, oBUSY, oFRAME_DONE
  );

  modport master (
    output iSTART, iVALID, iDATA, iREADY,
    input  oREADY, oVALID, oDATA, oBUSY, oFRAME_DONE
  );
endinterface

// File: rtl/fht_skid_buf.sv
// Two-entry output buffer with registered outputs.
// A full buffer still accepts a write in the cycle it is popped.
module fht_skid_buf #(
  parameter int D_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_BIT-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_BIT-1:0] out_data,
  output logic [1:0]       count
);
  logic [D_BIT-1:0] mem_q [2];
  logic [D_BIT-1:0] mem_d [2];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    out_valid = cnt_q != 2'd0;
    out_data  = mem_q[rp_q];
    count     = cnt_q;
    pop       = out_valid && out_ready;
    in_ready  = (cnt_q != 2'd2) || pop;
    push      = in_valid && in_ready;
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    if (push) begin
      mem_d[wp_q] = in_data;
      wp_d        = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fht_io_seq.sv
// FHT frame sequencer: bit-reversed load into 4 banks, hand-off to
// fht_control, then natural-order unload through a 2-entry buffer.
module fht_io_seq
  import fht_io_pkg::*;
#(
  parameter int A_BIT = `A_BIT,
  parameter int D_BIT = `D_BIT
) (
  input  logic               iCLK,
  input  logic               iRESET,
  fht_io_seq_if.slave        io,
  output logic [3:0]         oWE,
  output logic [A_BIT-1:0]   oWR_ADDR,
  output logic [A_BIT-1:0]   oRD_ADDR,
  output logic [D_BIT-1:0]   oWR_DATA,
  input  logic [4*D_BIT-1:0] iRD_DATA,
  output logic               oBANK_OWN,
  output logic               oFHT_START,
  input  logic               iFHT_RDY
);
  localparam int IW = A_BIT + 2;
  localparam logic [IW-1:0] LAST = '1;

  state_e        state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] o_q, o_d;
  logic          issued_q, issued_d;
  logic          infl_q, infl_d;
  logic          low_q, low_d;
  logic [1:0]    sel_q, sel_d;

  logic [IW-1:0]    rev;
  logic             in_fire, out_fire, rd_issue, last_out;
  logic             buf_valid, buf_in_rdy;
  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic [D_BIT-1:0] buf_data, rd_slice;

  always_comb begin
    rev      = IW'(bit_reverse(32'(k_q), IW));
    in_fire  = (state_q == ST_LOAD) && io.iVALID;
    out_fire = buf_valid && io.iREADY;
    last_out = out_fire && (o_q == LAST);
    // Reserve a buffer slot for every read still in the bank pipeline.
    occ = {1'b0, buf_cnt} + {2'b0, infl_q} - {2'b0, out_fire};
    rd_issue = (state_q == ST_UNLOAD) && !issued_q
             && (occ < 3'd2) && buf_in_rdy;
    rd_slice = iRD_DATA[int'(sel_q)*D_BIT +: D_BIT];

    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    o_d      = o_q;
    issued_d = issued_q;
    low_d    = low_q;
    infl_d   = rd_issue;
    sel_d    = j_q[IW-1:A_BIT];

    unique case (state_q)
      ST_IDLE: begin
        if (io.iSTART) begin
          state_d  = ST_LOAD;
          k_d      = '0;
          j_d      = '0;
          o_d      = '0;
          issued_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_fire) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST) state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        low_d   = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!iFHT_RDY) low_d = 1'b1;
        else if (low_q) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (rd_issue) begin
          j_d = j_q + 1'b1;
          if (j_q == LAST) issued_d = 1'b1;
        end
        if (out_fire) o_d = o_q + 1'b1;
        if (last_out) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    io.oREADY      = state_q == ST_LOAD;
    io.oVALID      = buf_valid;
    io.oDATA       = buf_data;
    io.oBUSY       = state_q != ST_IDLE;
    io.oFRAME_DONE = (state_q == ST_UNLOAD) && last_out;
    oWE        = in_fire ? (4'b0001 << rev[IW-1:A_BIT]) : 4'b0000;
    oWR_ADDR   = rev[A_BIT-1:0];
    oWR_DATA   = in_fire ? io.iDATA : '0;
    oRD_ADDR   = j_q[A_BIT-1:0];
    oBANK_OWN  = !((state_q == ST_KICK) || (state_q == ST_RUN));
    oFHT_START = state_q == ST_KICK;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      o_q      <= '0;
      issued_q <= 1'b0;
      infl_q   <= 1'b0;
      low_q    <= 1'b0;
      sel_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      o_q      <= o_d;
      issued_q <= issued_d;
      infl_q   <= infl_d;
      low_q    <= low_d;
      sel_q    <= sel_d;
    end
  end

  fht_skid_buf #(
    .D_BIT(D_BIT)
  ) u_buf (
    .clk      (iCLK),
    .rst      (iRESET),
    .in_valid (infl_q),
    .in_ready (buf_in_rdy),
    .in_data  (rd_slice),
    .out_valid(buf_valid),
    .out_ready(io.iREADY),
    .out_data (buf_data),
    .count    (buf_cnt)
  );
endmodule

// File: tb/tb_fht_io_seq.sv
// Scoreboard bench for fht_io_seq with a bank model and an fht_control model.
// Stimulus queues expected writes/outputs; monitors pop and compare.
module tb_fht_io_seq;
  localparam int A_BIT = 2;
  localparam int D_BIT = 8;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fht_io_seq_if #(.D_BIT(D_BIT)) io ();

  logic [3:0]         we;
  logic [A_BIT-1:0]   wr_addr, rd_addr;
  logic [D_BIT-1:0]   wr_data;
  logic [4*D_BIT-1:0] rd_data;
  logic               bank_own, fht_start, fht_rdy;

  fht_io_seq #(
    .A_BIT(A_BIT),
    .D_BIT(D_BIT)
  ) dut (
    .iCLK      (clk),
    .iRESET    (rst),
    .io        (io),
    .oWE       (we),
    .oWR_ADDR  (wr_addr),
    .oRD_ADDR  (rd_addr),
    .oWR_DATA  (wr_data),
    .iRD_DATA  (rd_data),
    .oBANK_OWN (bank_own),
    .oFHT_START(fht_start),
    .iFHT_RDY  (fht_rdy)
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bank RAMs; the fht_control stand-in writes the "transformed" pattern.
  logic [D_BIT-1:0] mem [4][4];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 4; a++) begin
        if (fht_start) mem[b][a] <= D_BIT'(16 * b + a);
        else if (bank_own && we[b] && wr_addr == 2'(a)) mem[b][a] <= wr_data;
      end
      rd_data[b*D_BIT +: D_BIT] <= mem[b][rd_addr];
    end
  end

  int n_start = 0;
  initial begin
    fht_rdy = 1'b1;
    forever begin
      do @(negedge clk); while (!fht_start);
      @(posedge clk);
      #1 fht_rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1 fht_rdy = 1'b1;
    end
  end

  bit rnd_rdy = 1'b0;
  always @(posedge clk) begin
    #1 io.iREADY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct {
    logic [3:0]       we;
    logic [1:0]       addr;
    logic [D_BIT-1:0] data;
    bit               last;
  } wr_t;
  wr_t              wq[$];
  logic [D_BIT-1:0] oq[$];

  // Hand-derived bit reversal of k (4 bits): bank from k[1:0], addr from k[3:2].
  int bank_tab[4] = '{0, 2, 1, 3};
  int addr_tab[4] = '{0, 2, 1, 3};

  int last_wr_cyc = -100;
  always @(negedge clk) begin
    if (!rst && we != 4'b0) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", {we, wr_addr, wr_data}, 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("wr_port", {we, wr_addr, wr_data}, {e.we, e.addr, e.data});
        if (e.last) last_wr_cyc = cyc;
      end
    end
    if (fht_start) begin
      n_start++;
      check("kick_lat", cyc, last_wr_cyc + 1);
    end
    if (!rst && !fht_rdy) check("own_run", bank_own, 0);
  end

  logic own_prev = 1'b1, v_prev = 1'b0, f_prev = 1'b0;
  bit   want_first = 1'b0;
  int   entry_cyc = 0;
  int   done_cnt = 0;
  always @(negedge clk) begin
    logic fire;
    if (rst) begin
      own_prev = 1'b1;
      v_prev = 1'b0;
      f_prev = 1'b0;
      want_first = 1'b0;
    end else begin
      if (bank_own && !own_prev) begin
        entry_cyc = cyc;
        want_first = 1'b1;
      end
      if (io.oVALID && want_first) begin
        check("first_lat", cyc - entry_cyc, 2);
        want_first = 1'b0;
      end
      if (v_prev && !f_prev) check("valid_hold", io.oVALID, 1);
      fire = io.oVALID && io.iREADY;
      if (fire) begin
        if (oq.size() == 0) begin
          check("out_unexpected", io.oDATA, 0);
        end else begin
          logic [D_BIT-1:0] e;
          e = oq.pop_front();
          check("odata", io.oDATA, e);
          check("frame_done", io.oFRAME_DONE, oq.size() == 0);
          if (oq.size() == 0) done_cnt++;
        end
      end else if (io.oFRAME_DONE) begin
        check("done_nofire", 1, 0);
      end
      own_prev = bank_own;
      v_prev = io.oVALID;
      f_prev = fire;
    end
  end

  task automatic check_reset(string tag);
    check({tag, "_ready"}, io.oREADY, 0);
    check({tag, "_valid"}, io.oVALID, 0);
    check({tag, "_odata"}, io.oDATA, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_bank_own"}, bank_own, 1);
    check({tag, "_fht_start"}, fht_start, 0);
    check({tag, "_busy"}, io.oBUSY, 0);
    check({tag, "_done"}, io.oFRAME_DONE, 0);
  endtask

  task automatic load(logic [D_BIT-1:0] base, int cnt);
    io.iSTART = 1'b1;
    @(posedge clk);
    #1 io.iSTART = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      io.iVALID = 1'b1;
      io.iDATA  = base + D_BIT'(k);
      wq.push_back('{we: 4'b0001 << bank_tab[k % 4],
                     addr: 2'(addr_tab[k / 4]),
                     data: base + D_BIT'(k),
                     last: (k == N - 1)});
      @(posedge clk);
      #1;
    end
    io.iVALID = 1'b0;
  endtask

  task automatic run_frame(logic [D_BIT-1:0] base, bit poke);
    int s0, d0, t;
    s0 = n_start;
    d0 = done_cnt;
    load(base, N);
    for (int j = 0; j < N; j++) oq.push_back(D_BIT'(16 * (j / 4) + (j % 4)));
    if (poke) begin
      t = 0;
      while (fht_rdy && t < 50) begin @(posedge clk); #1; t++; end
      io.iSTART = 1'b1;
      @(posedge clk);
      #1 io.iSTART = 1'b0;
      t = 0;
      while (!bank_own && t < 50) begin @(posedge clk); #1; t++; end
      io.iSTART = 1'b1;
      @(posedge clk);
      #1 io.iSTART = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin @(posedge clk); #1; t++; end
    check("frame_finished", done_cnt - d0, 1);
    check("busy_after", io.oBUSY, 0);
    check("one_kick", n_start - s0, 1);
    check("wq_drained", wq.size(), 0);
    check("oq_drained", oq.size(), 0);
    oq.delete();
    wq.delete();
  endtask

  initial begin
    io.iSTART = 1'b0;
    io.iVALID = 1'b0;
    io.iDATA  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(8'h00, 1'b0);

    rnd_rdy = 1'b1;
    run_frame(8'h40, 1'b1);
    rnd_rdy = 1'b0;

    load(8'hA0, 7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset("abort");
    check("abort_wq", wq.size(), 0);
    wq.delete();

    run_frame(8'h80, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
